// File: rtl/prbs_pkg.sv
// Shared types and the Galois LFSR word-advance function for the PRBS generator/checker.
// Widths are bounded by MAX_W / MAX_NB so one function serves every parametrisation.
package prbs_pkg;

    localparam int MAX_W  = 64;
    localparam int MAX_NB = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic [MAX_W-1:0]  state;
        logic [MAX_NB-1:0] word;
    } galois_adv_t;

    // Chains nb single steps; bit i of the word is s[0] before step i.
    function automatic galois_adv_t galois_advance(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W:0]   poly,
                                                   input int               nb);
        galois_adv_t      res;
        logic [MAX_W-1:0] s;
        logic [MAX_W-1:0] taps;
        s        = state;
        taps     = MAX_W'(poly >> 1);
        res.word = '0;
        for (int i = 0; i < MAX_NB; i++) begin
            if (i < nb) begin
                res.word[i] = s[0];
                s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
            end
        end
        res.state = s;
        return res;
    endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// Galois LFSR state register with load/advance/hold; word is what the next advance emits.
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W:0]     POLY = 9'h11D,
    parameter int             NB   = 8,
    parameter logic [W-1:0]   SEED = W'(1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          adv,
    output logic [NB-1:0] word
);

    logic [W-1:0] state_reg;
    logic [W-1:0] state_next;
    galois_adv_t  adv_res;
    logic         unused_adv;

    always_comb begin
        adv_res = galois_advance(MAX_W'(state_reg), (MAX_W+1)'(POLY), NB);
    end

    assign state_next = adv_res.state[W-1:0];
    assign word       = adv_res.word[NB-1:0];
    assign unused_adv = ^adv_res;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= SEED;
        end else if (load) begin
            state_reg <= load_val;
        end else if (adv) begin
            state_reg <= state_next;
        end
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// Parallel PRBS generator plus aligning checker with lock detection and saturating bit-error count.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int           W        = 8,
    parameter logic [W:0]   POLY     = 9'h11D,
    parameter int           NB       = 8,
    parameter logic [W-1:0] SEED     = W'(1),
    parameter int           LOCK_CNT = 4,
    parameter int           LOSS_CNT = 4,
    parameter int           ECW      = 16
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           gen_en,
    input  logic           gen_load,
    input  logic [W-1:0]   gen_seed,
    output logic [NB-1:0]  gen_dout,
    output logic           gen_valid,
    input  logic           din_valid,
    input  logic [NB-1:0]  din,
    input  logic           chk_start,
    input  logic           err_clr,
    output logic           chk_locked,
    output logic           err_pulse,
    output logic [ECW-1:0] err_cnt
);

    localparam int CW = $clog2((LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT) + 1);
    localparam int PW = $clog2(NB + 1);

    // ---------------- generator ----------------
    logic [W-1:0]  gen_load_val;
    logic [NB-1:0] gen_word;
    logic          gen_adv;
    logic [NB-1:0] gen_dout_reg;
    logic          gen_valid_reg;

    // A zero seed would lock the LFSR in the all-zero state, so substitute 1.
    assign gen_load_val = (gen_seed == '0) ? W'(1) : gen_seed;
    assign gen_adv      = gen_en & ~gen_load;

    prbs_lfsr_core #(.W(W), .POLY(POLY), .NB(NB), .SEED(SEED)) u_gen (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (gen_load),
        .load_val (gen_load_val),
        .adv      (gen_adv),
        .word     (gen_word)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            gen_dout_reg  <= '0;
            gen_valid_reg <= 1'b0;
        end else begin
            gen_valid_reg <= gen_adv;
            if (gen_adv) begin
                gen_dout_reg <= gen_word;
            end
        end
    end

    assign gen_dout  = gen_dout_reg;
    assign gen_valid = gen_valid_reg;

    // ---------------- checker ----------------
    chk_state_t     chk_state_reg;
    logic [CW-1:0]  match_cnt_reg;
    logic [CW-1:0]  bad_cnt_reg;
    logic [ECW-1:0] err_cnt_reg;
    logic           err_pulse_reg;
    logic           chk_locked_reg;

    logic [NB-1:0]  chk_word;
    logic [NB-1:0]  diff;
    logic [PW-1:0]  diff_pop;
    logic           word_match;
    logic           lock_hit;
    logic           bad_hit;
    logic           chk_load;
    logic           chk_adv;
    logic [ECW-1:0] err_base;
    logic [ECW:0]   err_sum;
    logic [ECW-1:0] err_sat;

    prbs_lfsr_core #(.W(W), .POLY(POLY), .NB(NB), .SEED(SEED)) u_chk (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (chk_load),
        .load_val (SEED),
        .adv      (chk_adv),
        .word     (chk_word)
    );

    for (genvar gi = 0; gi < NB; gi++) begin : g_diff
        assign diff[gi] = din[gi] ^ chk_word[gi];
    end

    always_comb begin
        diff_pop = '0;
        for (int i = 0; i < NB; i++) begin
            diff_pop = diff_pop + PW'(diff[i]);
        end
    end

    assign word_match = (diff == '0);
    assign lock_hit   = (match_cnt_reg + CW'(1)) == CW'(LOCK_CNT);
    assign bad_hit    = (bad_cnt_reg + CW'(1)) == CW'(LOSS_CNT);

    // A clear in the same cycle as an increment leaves only that word's popcount.
    assign err_base = err_clr ? '0 : err_cnt_reg;
    assign err_sum  = {1'b0, err_base} + (ECW+1)'(diff_pop);
    assign err_sat  = err_sum[ECW] ? '1 : err_sum[ECW-1:0];

    always_comb begin
        chk_load = 1'b0;
        chk_adv  = 1'b0;
        if (chk_start) begin
            chk_load = 1'b1;
        end else if (din_valid) begin
            case (chk_state_reg)
                HUNT: begin
                    if (word_match) chk_adv  = 1'b1;
                    else            chk_load = 1'b1;
                end
                LOCKED: begin
                    if (!word_match && bad_hit) chk_load = 1'b1;
                    else                        chk_adv  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chk_state_reg  <= IDLE;
            match_cnt_reg  <= '0;
            bad_cnt_reg    <= '0;
            err_cnt_reg    <= '0;
            err_pulse_reg  <= 1'b0;
            chk_locked_reg <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            if (err_clr) begin
                err_cnt_reg <= '0;
            end
            if (chk_start) begin
                chk_state_reg  <= HUNT;
                match_cnt_reg  <= '0;
                chk_locked_reg <= 1'b0;
            end else if (din_valid) begin
                case (chk_state_reg)
                    HUNT: begin
                        if (!word_match) begin
                            match_cnt_reg <= '0;
                        end else if (lock_hit) begin
                            chk_state_reg  <= LOCKED;
                            match_cnt_reg  <= '0;
                            bad_cnt_reg    <= '0;
                            chk_locked_reg <= 1'b1;
                        end else begin
                            match_cnt_reg <= match_cnt_reg + CW'(1);
                        end
                    end
                    LOCKED: begin
                        if (word_match) begin
                            bad_cnt_reg <= '0;
                        end else begin
                            err_cnt_reg   <= err_sat;
                            err_pulse_reg <= 1'b1;
                            if (bad_hit) begin
                                chk_state_reg  <= HUNT;
                                match_cnt_reg  <= '0;
                                bad_cnt_reg    <= '0;
                                chk_locked_reg <= 1'b0;
                            end else begin
                                bad_cnt_reg <= bad_cnt_reg + CW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign chk_locked = chk_locked_reg;
    assign err_pulse  = err_pulse_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Loopback bench: generator output feeds the checker; a reference model fills a scoreboard each cycle.
module tb_prbs_gen_chk;
    import prbs_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [7:0]  dout;
        logic        locked;
        logic        pulse;
        logic [15:0] ecnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        gen_en, gen_load, chk_start, err_clr;
    logic [7:0]  gen_seed;
    logic [7:0]  gen_dout;
    logic        gen_valid;
    logic        din_valid;
    logic [7:0]  din;
    logic [7:0]  corrupt;
    logic        chk_locked, err_pulse;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    obs_t sb[$];

    // reference model state
    logic [7:0]  m_gs, m_dout, m_cs;
    logic        m_valid, m_locked, m_pulse;
    logic [15:0] m_ecnt;
    chk_state_t  m_st;
    int          m_match, m_bad;

    assign din       = gen_dout ^ corrupt;
    assign din_valid = gen_valid;

    prbs_gen_chk dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .gen_en     (gen_en),
        .gen_load   (gen_load),
        .gen_seed   (gen_seed),
        .gen_dout   (gen_dout),
        .gen_valid  (gen_valid),
        .din_valid  (din_valid),
        .din        (din),
        .chk_start  (chk_start),
        .err_clr    (err_clr),
        .chk_locked (chk_locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {next_state, word} for 8 Galois steps with x^8+x^4+x^3+x^2+1
    function automatic logic [15:0] ref_adv(input logic [7:0] s_in);
        logic [7:0] s, w, taps;
        logic [8:0] poly;
        poly = 9'h11D;
        taps = poly[8:1];
        s = s_in;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[i] = s[0];
            s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
        end
        return {s, w};
    endfunction

    function automatic obs_t observe();
        return obs_t'({gen_valid, gen_dout, chk_locked, err_pulse, err_cnt});
    endfunction

    task automatic model_reset();
        m_gs = 8'h01; m_cs = 8'h01; m_dout = '0; m_valid = 1'b0;
        m_st = IDLE; m_match = 0; m_bad = 0;
        m_locked = 1'b0; m_pulse = 1'b0; m_ecnt = '0;
        sb.delete();
    endtask

    // Drive one cycle, predict the outputs after the edge, push them, then step past the edge.
    task automatic drive_cycle(input logic en, input logic load, input logic [7:0] seed,
                               input logic start, input logic clr, input logic [7:0] mask);
        logic [15:0] r;
        logic [7:0]  dw;
        int          tmp;
        gen_en = en; gen_load = load; gen_seed = seed;
        chk_start = start; err_clr = clr; corrupt = mask;
        dw = m_dout ^ mask;
        m_pulse = 1'b0;
        if (clr) m_ecnt = '0;
        if (start) begin
            m_st = HUNT; m_cs = 8'h01; m_match = 0;
        end else if (m_valid) begin
            r = ref_adv(m_cs);
            if (m_st == HUNT) begin
                if (dw == r[7:0]) begin
                    m_cs = r[15:8];
                    m_match++;
                    if (m_match == 4) begin m_st = LOCKED; m_bad = 0; end
                end else begin
                    m_cs = 8'h01; m_match = 0;
                end
            end else if (m_st == LOCKED) begin
                if (dw != r[7:0]) begin
                    tmp = int'(m_ecnt) + $countones(dw ^ r[7:0]);
                    m_ecnt = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
                    m_pulse = 1'b1;
                    m_bad++;
                    if (m_bad == 4) begin m_st = HUNT; m_cs = 8'h01; m_match = 0; end
                    else m_cs = r[15:8];
                end else begin
                    m_bad = 0; m_cs = r[15:8];
                end
            end
        end
        m_locked = (m_st == LOCKED);
        if (load) begin
            m_gs = (seed == 8'h00) ? 8'h01 : seed;
            m_valid = 1'b0;
        end else if (en) begin
            r = ref_adv(m_gs);
            m_dout = r[7:0]; m_gs = r[15:8]; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        sb.push_back(obs_t'({m_valid, m_dout, m_locked, m_pulse, m_ecnt}));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        arst_n = 1'b0; gen_en = 0; gen_load = 0; gen_seed = 0;
        chk_start = 0; err_clr = 0; corrupt = 0;
        model_reset();
        #12;
        o = observe();
        n_cmp++;
        if (o !== obs_t'(0)) begin n_err++; $display("FAIL reset_outputs got=%h want=0", o); end
        n_cmp++;
        if (dut.chk_state_reg !== IDLE) begin n_err++; $display("FAIL reset_fsm got=%0d want=IDLE", dut.chk_state_reg); end
        $display("[%0t] reset: outputs=%h", $time, o);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_gen_first();
        obs_t o, e;
        drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL gen_first got=%h want=%h", o, e); end
        n_cmp++;
        if (gen_dout !== 8'h8D || gen_valid !== 1'b1) begin
            n_err++; $display("FAIL gen_first_word got=%h/%b want=8d/1", gen_dout, gen_valid);
        end
        n_cmp++;
        if (dut.u_gen.state_reg !== 8'h83) begin
            n_err++; $display("FAIL gen_first_state got=%h want=83", dut.u_gen.state_reg);
        end
        $display("[%0t] gen_en: dout=%h valid=%b", $time, gen_dout, gen_valid);
        drive_cycle(0, 0, 8'h00, 0, 0, 8'h00);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e || gen_valid !== 1'b0 || gen_dout !== 8'h8D) begin
            n_err++; $display("FAIL gen_hold got=%h want=%h", o, e);
        end
        $display("[%0t] gen idle: dout=%h valid=%b", $time, gen_dout, gen_valid);
    endtask

    task automatic test_load_priority();
        obs_t o, e;
        drive_cycle(1, 1, 8'h00, 0, 0, 8'h00);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e || gen_valid !== 1'b0 || gen_dout !== 8'h8D) begin
            n_err++; $display("FAIL load_prio got=%h want=%h", o, e);
        end
        n_cmp++;
        if (dut.u_gen.state_reg !== 8'h01) begin
            n_err++; $display("FAIL load_zero_seed got=%h want=01", dut.u_gen.state_reg);
        end
        $display("[%0t] load seed=0 with en: dout=%h valid=%b", $time, gen_dout, gen_valid);
    endtask

    task automatic test_lock();
        obs_t o, e;
        drive_cycle(1, 0, 8'h00, 1, 0, 8'h00);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL lock_start got=%h want=%h", o, e); end
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
            e = sb.pop_front(); o = observe();
            n_cmp++;
            if (o !== e || chk_locked !== (k == 4)) begin
                n_err++; $display("FAIL lock_word%0d got=%h want=%h", k, o, e);
            end
            $display("[%0t] hunt word %0d: din=%h locked=%b", $time, k, din, chk_locked);
        end
        for (int k = 0; k < 255; k++) begin
            drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
            e = sb.pop_front(); o = observe();
            n_cmp++;
            if (o !== e || err_cnt !== 16'd0 || chk_locked !== 1'b1) begin
                n_err++; $display("FAIL lock_run%0d got=%h want=%h", k, o, e);
            end
            $display("[%0t] locked word %0d: din=%h ecnt=%0d", $time, k, din, err_cnt);
        end
    endtask

    task automatic test_err_inject();
        obs_t o, e;
        drive_cycle(1, 0, 8'h00, 0, 0, 8'h21);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e || err_pulse !== 1'b1 || err_cnt !== 16'd2) begin
            n_err++; $display("FAIL err_two_bits got=%h want=%h", o, e);
        end
        $display("[%0t] corrupt 0x21: pulse=%b ecnt=%0d", $time, err_pulse, err_cnt);
        drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e || err_pulse !== 1'b0 || err_cnt !== 16'd2) begin
            n_err++; $display("FAIL err_pulse_width got=%h want=%h", o, e);
        end
        $display("[%0t] clean: pulse=%b ecnt=%0d", $time, err_pulse, err_cnt);
        drive_cycle(1, 0, 8'h00, 0, 1, 8'h07);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e || err_cnt !== 16'd3) begin
            n_err++; $display("FAIL err_clr_same_cycle got=%h want=%h", o, e);
        end
        $display("[%0t] corrupt 0x07 + clr: ecnt=%0d", $time, err_cnt);
        drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e || chk_locked !== 1'b1) begin
            n_err++; $display("FAIL err_still_locked got=%h want=%h", o, e);
        end
        $display("[%0t] clean: locked=%b ecnt=%0d", $time, chk_locked, err_cnt);
    endtask

    task automatic test_loss_relock();
        obs_t o, e;
        int   waited;
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1, 0, 8'h00, 0, 0, 8'hFF);
            e = sb.pop_front(); o = observe();
            n_cmp++;
            if (o !== e || chk_locked !== (k < 4) || err_pulse !== 1'b1) begin
                n_err++; $display("FAIL loss_word%0d got=%h want=%h", k, o, e);
            end
            $display("[%0t] bad word %0d: locked=%b ecnt=%0d", $time, k, chk_locked, err_cnt);
        end
        n_cmp++;
        if (dut.chk_state_reg !== HUNT || err_cnt !== 16'd35) begin
            n_err++; $display("FAIL loss_state got=%0d/%0d want=HUNT/35", dut.chk_state_reg, err_cnt);
        end
        waited = 0;
        while (chk_locked !== 1'b1 && waited < 300) begin
            drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
            e = sb.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL relock_cyc%0d got=%h want=%h", waited, o, e); end
            $display("[%0t] relock cycle %0d: din=%h locked=%b", $time, waited, din, chk_locked);
            waited++;
        end
        n_cmp++;
        if (chk_locked !== 1'b1 || err_cnt !== 16'd35) begin
            n_err++; $display("FAIL relock_timeout got=%b/%0d want=1/35", chk_locked, err_cnt);
        end
    endtask

    task automatic test_midstream_reset();
        obs_t o, e;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
            e = sb.pop_front(); o = observe();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL pre_reset%0d got=%h want=%h", k, o, e); end
            $display("[%0t] pre-reset word %0d: dout=%h", $time, k, gen_dout);
        end
        #1;
        arst_n = 1'b0;
        #1;
        o = observe();
        n_cmp++;
        if (o !== obs_t'(0)) begin n_err++; $display("FAIL async_reset got=%h want=0", o); end
        n_cmp++;
        if (dut.u_gen.state_reg !== 8'h01 || dut.chk_state_reg !== IDLE) begin
            n_err++; $display("FAIL async_reset_state got=%h/%0d want=01/IDLE",
                              dut.u_gen.state_reg, dut.chk_state_reg);
        end
        $display("[%0t] async reset: outputs=%h", $time, o);
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        drive_cycle(1, 0, 8'h00, 0, 0, 8'h00);
        e = sb.pop_front(); o = observe();
        n_cmp++;
        if (o !== e || gen_dout !== 8'h8D || gen_valid !== 1'b1) begin
            n_err++; $display("FAIL post_reset_word got=%h want=%h", o, e);
        end
        $display("[%0t] post-reset gen_en: dout=%h", $time, gen_dout);
    endtask

    initial begin
        test_reset();
        test_gen_first();
        test_load_priority();
        test_lock();
        test_err_inject();
        test_loss_relock();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
